float_to_int: RTL and testbench
===============================

// Module: float_to_int
// PURPOSE
//  Multi-cycle converter from IEEE-754 binary32 to signed int32, round-to-nearest-even.
//  Unpacks the float format that the adder packs; feeds integer datapaths and checks adder output.
//  Start/done handshake. One alignment shift per cycle.
// PARAMETERS
//  none (fixed binary32 -> int32). Localparams: BIAS=127, FRAC_W=23, INT_W=32.
// PORTS
//  clk      in   1   clock, all state updates on posedge
//  rst      in   1   reset, synchronous, active-low
//  start    in   1   request; sampled only in IDLE
//  a        in   32  binary32 operand; sampled with start
//  busy     out  1   high in every state except IDLE
//  done     out  1   one-cycle pulse; result/flags valid
//  result   out  32  signed int32; held until next done
//  invalid  out  1   NaN, Inf or out-of-range; held with result
//  inexact  out  1   rounding discarded nonzero bits; held with result
// BEHAVIOUR
//  Reset (rst=0 at posedge, any state, including mid-conversion):
//   - state=IDLE; busy=0; done=0; result=0; invalid=0; inexact=0.
//   - Any in-flight conversion is dropped.
//  FSM states: IDLE, UNPACK, SHIFT, ROUND, DONE.
//  IDLE: start=1 -> latch a, go UNPACK. start outside IDLE is ignored (no queueing).
//  UNPACK: sign=a[31], E=a[30:23]-127, W={1,a[22:0]}, guard=sticky=0.
//   - exp==255, NaN -> 0x7FFFFFFF, invalid=1 -> DONE.
//   - exp==255, +Inf -> 0x7FFFFFFF, invalid=1 -> DONE.
//   - exp==255, -Inf -> 0x80000000, invalid=1 -> DONE.
//   - exp==0 (zero/subnormal) -> 0, inexact=(frac!=0) -> DONE.
//   - exp<126 (|x|<0.5) -> 0, inexact=1 -> DONE.
//   - E>=31: a==0xCF000000 -> 0x80000000, no flags.
//     Else saturate: 0x7FFFFFFF if +, 0x80000000 if -, invalid=1. -> DONE.
//   - Otherwise S=|E-23| (0..24), direction=left if E>23.
//     S>0 -> SHIFT with cnt=S. S==0 -> ROUND.
//  SHIFT: one bit per cycle; cnt decrements; leave to ROUND when cnt reaches 0.
//   - Left: W<<=1, zero fill. E<=30 so W fits 31 bits.
//   - Right: sticky|=guard; guard=W[0]; W>>=1.
//  ROUND: inc=guard&(sticky|W[0]); mag=W+inc; inexact=guard|sticky.
//   - result = sign ? -mag : mag, in 32-bit two's complement.
//   - mag>2^31-1 with sign=0 -> saturate, invalid=1. Unreachable; kept as guard.
//   - Go DONE.
//  DONE: done=1 for exactly one cycle; result/flags already registered; next -> IDLE.
//  Latency, start accepted on edge t0:
//   - done high after edge t0+2 on special paths.
//   - done high after edge t0+3+S on normal path. Max t0+27.
//   - Back-to-back: start may be asserted the cycle done falls, i.e. in IDLE.
//  Width rules:
//   - W is 32 bits; cnt is 5 bits; E computed as 9-bit signed.
//   - -0.0 converts to 0 with no flags.
// STRUCTURE
//  Shared package float_pkg:
//   - BIAS, EXP_W=8, FRAC_W=23, EXP_MAX=255, INT_MAX=0x7FFFFFFF, INT_MIN=0x80000000.
//   - FSM state encoding, shared with float_adder.
//  Sub-module fp_unpack (combinational):
//   - Splits sign/exp/frac.
//   - Outputs is_nan, is_inf, is_zero_or_sub, unbiased E.
//   - Reusable by float_adder.
//  FSM, shifter, rounder and negation stay in float_to_int.
// TESTING
//  1. 0x3F800000 (1.0) -> result=1, inexact=0, invalid=0, done at t0+26 (S=23).
//  2. RNE ties:
//     - 0x40200000 (2.5) -> 2.
//     - 0x40600000 (3.5) -> 4.
//     - 0x3F000000 (0.5) -> 0.
//     - 0xBFC00000 (-1.5) -> 0xFFFFFFFE.
//     All with inexact=1.
//  3. Range edges:
//     - 0x4EFFFFFF -> 0x7FFFFF80, no flags, done t0+10.
//     - 0xCF000000 -> 0x80000000, no flags.
//     - 0x4F000000 -> 0x7FFFFFFF, invalid=1.
//  4. Specials:
//     - 0x7FC00000 -> 0x7FFFFFFF inv.
//     - 0xFF800000 -> 0x80000000 inv.
//     - 0x00000001 -> 0, inexact.
//     - 0x80000000 -> 0, no flags.
//     - 0x3E800000 -> 0, inexact.
//     All done at t0+2.
//  5. Handshake:
//     - start held high during busy -> exactly one done per accepted start.
//     - New a during busy does not alter result.
//     - Back-to-back requests are spaced by latency+1.
//  6. rst=0 mid-SHIFT on 1.0 conversion:
//     - Next cycle busy=0, done=0, result=0.
//     - Never pulses done for the aborted request.
//     - Following 0x41200000 -> 10.

Source files
------------

// File: rtl/float_pkg.sv
// Shared binary32 constants, FSM encoding and result record for the float
// converter and adder blocks.
package float_pkg;

  localparam int BIAS    = 127;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int INT_W   = 32;
  localparam int EXP_MAX = 255;

  localparam logic [INT_W-1:0] INT_MAX     = 32'h7FFF_FFFF;
  localparam logic [INT_W-1:0] INT_MIN     = 32'h8000_0000;
  // -2^31 as binary32: the only E==31 value that fits in int32
  localparam logic [31:0]      FLT_INT_MIN = 32'hCF00_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SHIFT,
    ST_ROUND,
    ST_DONE
  } fsm_state_t;

  typedef struct packed {
    logic [INT_W-1:0] res;
    logic             inv;
    logic             inx;
  } cvt_res_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational binary32 field splitter with special-value classification.
module fp_unpack
  import float_pkg::*;
(
  input  logic [31:0]        a,
  output logic               sign,
  output logic [EXP_W-1:0]   exp,
  output logic [FRAC_W-1:0]  frac,
  output logic               is_nan,
  output logic               is_inf,
  output logic               is_zero_or_sub,
  output logic signed [EXP_W:0] e_unb
);

  assign sign           = a[31];
  assign exp            = a[30:23];
  assign frac           = a[22:0];
  assign is_nan         = (exp == EXP_W'(EXP_MAX)) && (frac != '0);
  assign is_inf         = (exp == EXP_W'(EXP_MAX)) && (frac == '0);
  assign is_zero_or_sub = (exp == '0);
  assign e_unb          = (EXP_W+1)'($signed({1'b0, exp}) - BIAS);

endmodule

// File: rtl/float_to_int.sv
// Multi-cycle binary32 -> int32 converter, round-to-nearest-even, with a
// start/done handshake and a one-bit-per-cycle alignment shifter.
module float_to_int
  import float_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      a,
  output logic             busy,
  output logic             done,
  output logic [INT_W-1:0] result,
  output logic             invalid,
  output logic             inexact
);

  fsm_state_t state, state_nxt;

  logic [31:0]       a_r;
  logic [31:0]       w;
  logic [4:0]        cnt;
  logic              sgn, left, guard, sticky;
  cvt_res_t          res_r;

  logic              u_sign, u_nan, u_inf, u_zs;
  logic [EXP_W-1:0]  u_exp;
  logic [FRAC_W-1:0] u_frac;
  logic signed [8:0] u_e;

  logic              special;
  cvt_res_t          spec_res;
  logic signed [8:0] e_diff;
  logic [4:0]        sh_amt;

  function automatic logic [INT_W-1:0] sat_int(input logic s);
    return s ? INT_MIN : INT_MAX;
  endfunction

  function automatic cvt_res_t round_rne(input logic s, input logic [31:0] wv,
                                         input logic g, input logic st);
    logic [31:0] mag;
    cvt_res_t    r;
    mag   = wv + {31'd0, g & (st | wv[0])};
    r.inx = g | st;
    r.inv = 1'b0;
    if (!s && (mag > INT_MAX)) begin
      r.res = INT_MAX;
      r.inv = 1'b1;
    end else begin
      r.res = s ? (32'd0 - mag) : mag;
    end
    return r;
  endfunction

  fp_unpack u_unpack (
    .a              (a_r),
    .sign           (u_sign),
    .exp            (u_exp),
    .frac           (u_frac),
    .is_nan         (u_nan),
    .is_inf         (u_inf),
    .is_zero_or_sub (u_zs),
    .e_unb          (u_e)
  );

  always_comb begin
    special  = 1'b1;
    spec_res = '0;
    e_diff   = u_e - 9'sd23;
    sh_amt   = 5'(e_diff[8] ? -e_diff : e_diff);
    if (u_nan) begin
      spec_res = '{res: INT_MAX, inv: 1'b1, inx: 1'b0};
    end else if (u_inf) begin
      spec_res = '{res: sat_int(u_sign), inv: 1'b1, inx: 1'b0};
    end else if (u_zs) begin
      spec_res.inx = (u_frac != '0);
    end else if (u_exp < 8'd126) begin
      spec_res.inx = 1'b1;
    end else if (u_e >= 9'sd31) begin
      if (a_r == FLT_INT_MIN) spec_res.res = INT_MIN;
      else spec_res = '{res: sat_int(u_sign), inv: 1'b1, inx: 1'b0};
    end else begin
      special = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_UNPACK;
      ST_UNPACK: begin
        if (special)            state_nxt = ST_DONE;
        else if (sh_amt == '0)  state_nxt = ST_ROUND;
        else                    state_nxt = ST_SHIFT;
      end
      ST_SHIFT:  if (cnt == 5'd1) state_nxt = ST_ROUND;
      ST_ROUND:  state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  assign busy = (state != ST_IDLE);

  // Working registers: only meaningful along an accepted conversion
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: if (start) a_r <= a;
      ST_UNPACK: begin
        w      <= {8'd0, 1'b1, u_frac};
        sgn    <= u_sign;
        left   <= !e_diff[8];
        guard  <= 1'b0;
        sticky <= 1'b0;
        cnt    <= sh_amt;
        res_r  <= spec_res;
      end
      ST_SHIFT: begin
        cnt <= cnt - 5'd1;
        if (left) begin
          w <= {w[30:0], 1'b0};
        end else begin
          w      <= {1'b0, w[31:1]};
          guard  <= w[0];
          sticky <= sticky | guard;
        end
      end
      ST_ROUND: res_r <= round_rne(sgn, w, guard, sticky);
      default: ;
    endcase
  end

  // Outputs change only together with the done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      done    <= 1'b0;
      result  <= '0;
      invalid <= 1'b0;
      inexact <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      if (state == ST_DONE) {result, invalid, inexact} <= res_r;
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Bench for float_to_int: directed vector table, handshake/reset sequences and
// random operands against an arithmetic reference model.
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic        busy, done, invalid, inexact;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  float_to_int dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .invalid (invalid),
    .inexact (inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Value = m * 2^(exp-150); round by quotient/remainder, then range-check.
  function automatic void model(input logic [31:0] x, output logic [31:0] r,
                                output logic inv, output logic inx, output int lat);
    int     e, n;
    longint m, q, rem, half, v;
    e   = int'(x[30:23]);
    m   = longint'({1'b1, x[22:0]});
    inv = 1'b0;
    inx = 1'b0;
    r   = '0;
    if (e == 255) begin
      inv = 1'b1;
      r   = (x[22:0] != 0 || !x[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
      lat = 2;
      return;
    end
    if (e == 0) begin
      inx = (x[22:0] != 0);
      lat = 2;
      return;
    end
    lat = (e < 126 || e >= 158) ? 2 : 3 + ((e > 150) ? e - 150 : 150 - e);
    if (e >= 150) begin
      q = (e - 150 > 40) ? (longint'(1) <<< 62) : (m <<< (e - 150));
    end else begin
      n = 150 - e;
      if (n > 30) begin
        q   = 0;
        inx = 1'b1;
      end else begin
        q    = m >>> n;
        rem  = m - (q <<< n);
        half = longint'(1) <<< (n - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        inx  = (rem != 0);
      end
    end
    v = x[31] ? -q : q;
    if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
      inv = 1'b1;
      inx = 1'b0;
      r   = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      r = v[31:0];
    end
  endfunction

  // One request; scrambles a during busy; lat=0 means no done within budget.
  task automatic convert(input logic [31:0] x, output logic [31:0] r,
                         output logic inv, output logic inx, output int lat);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    lat   = 0;
    r     = 'x;
    inv   = 1'bx;
    inx   = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        r   = result;
        inv = invalid;
        inx = inexact;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] x,
                               input logic [31:0] er, input logic einv,
                               input logic einx, input int elat);
    logic [31:0] r;
    logic        inv, inx;
    int          lat;
    convert(x, r, inv, inx, lat);
    chk({tag, " result"},  r,   er);
    chk({tag, " invalid"}, 32'(inv), 32'(einv));
    chk({tag, " inexact"}, 32'(inx), 32'(einx));
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    if (lat != 0) begin
      @(posedge clk);
      #1;
      chk({tag, " done width"}, 32'(done), 32'd0);
    end
  endtask

  vec_t vecs[15];

  initial begin
    logic [31:0] er, x;
    logic        einv, einx;
    int          elat, dn_cnt;
    int          dn[$];

    vecs[0]  = '{a: 32'h3F80_0000, res: 32'h0000_0001, inv: 1'b0, inx: 1'b0, lat: 26};
    vecs[1]  = '{a: 32'h4020_0000, res: 32'h0000_0002, inv: 1'b0, inx: 1'b1, lat: 25};
    vecs[2]  = '{a: 32'h4060_0000, res: 32'h0000_0004, inv: 1'b0, inx: 1'b1, lat: 25};
    vecs[3]  = '{a: 32'h3F00_0000, res: 32'h0000_0000, inv: 1'b0, inx: 1'b1, lat: 27};
    vecs[4]  = '{a: 32'hBFC0_0000, res: 32'hFFFF_FFFE, inv: 1'b0, inx: 1'b1, lat: 26};
    vecs[5]  = '{a: 32'h4EFF_FFFF, res: 32'h7FFF_FF80, inv: 1'b0, inx: 1'b0, lat: 10};
    vecs[6]  = '{a: 32'hCF00_0000, res: 32'h8000_0000, inv: 1'b0, inx: 1'b0, lat: 2};
    vecs[7]  = '{a: 32'h4F00_0000, res: 32'h7FFF_FFFF, inv: 1'b1, inx: 1'b0, lat: 2};
    vecs[8]  = '{a: 32'h7FC0_0000, res: 32'h7FFF_FFFF, inv: 1'b1, inx: 1'b0, lat: 2};
    vecs[9]  = '{a: 32'hFF80_0000, res: 32'h8000_0000, inv: 1'b1, inx: 1'b0, lat: 2};
    vecs[10] = '{a: 32'h0000_0001, res: 32'h0000_0000, inv: 1'b0, inx: 1'b1, lat: 2};
    vecs[11] = '{a: 32'h8000_0000, res: 32'h0000_0000, inv: 1'b0, inx: 1'b0, lat: 2};
    vecs[12] = '{a: 32'h3E80_0000, res: 32'h0000_0000, inv: 1'b0, inx: 1'b1, lat: 2};
    vecs[13] = '{a: 32'h4B00_0000, res: 32'h0080_0000, inv: 1'b0, inx: 1'b0, lat: 3};
    vecs[14] = '{a: 32'h7F80_0000, res: 32'h7FFF_FFFF, inv: 1'b1, inx: 1'b0, lat: 2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",    32'(busy),    32'd0);
    chk("reset done",    32'(done),    32'd0);
    chk("reset result",  result,       32'd0);
    chk("reset invalid", 32'(invalid), 32'd0);
    chk("reset inexact", 32'(inexact), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i])
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].res,
                    vecs[i].inv, vecs[i].inx, vecs[i].lat);

    // start held high: one done per accepted request, spaced latency+1
    @(negedge clk);
    start = 1'b1;
    a     = 32'h3F80_0000;
    @(posedge clk);
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dn.push_back(i);
        chk("held start result", result, 32'd1);
      end
    end
    start = 1'b0;
    chk("held start done count", 32'(dn.size()), 32'd3);
    if (dn.size() == 3) begin
      chk("held start done0", 32'(dn[0]), 32'd26);
      chk("held start done1", 32'(dn[1]), 32'd53);
      chk("held start done2", 32'(dn[2]), 32'd80);
    end

    // start pulses and new operands while busy are ignored
    begin
      logic [31:0] r;
      logic        inv, inx;
      int          lat;
      @(negedge clk);
      start = 1'b1;
      a     = 32'h4020_0000;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      a     = 32'h4F00_0000;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b0;
      a     = 32'h0;
      lat   = 0;
      r     = 'x;
      inv   = 1'bx;
      inx   = 1'bx;
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk);
        #1;
        if (done) begin
          lat = i + 7;
          r   = result;
          inv = invalid;
          inx = inexact;
          break;
        end
      end
      chk("busy start result",  r,          32'd2);
      chk("busy start invalid", 32'(inv),   32'd0);
      chk("busy start inexact", 32'(inx),   32'd1);
      chk("busy start latency", 32'(lat),   32'd25);
      dn_cnt = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk);
        #1;
        if (done) dn_cnt++;
      end
      chk("busy start extra done", 32'(dn_cnt), 32'd0);
    end

    // Reset during the shift phase drops the request
    @(negedge clk);
    start = 1'b1;
    a     = 32'h3F80_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort busy",    32'(busy),    32'd0);
    chk("abort done",    32'(done),    32'd0);
    chk("abort result",  result,       32'd0);
    chk("abort inexact", 32'(inexact), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dn_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) dn_cnt++;
    end
    chk("abort no done", 32'(dn_cnt), 32'd0);
    run_and_check("after abort", 32'h4120_0000, 32'd10, 1'b0, 1'b0, 23);

    // Random operands against the arithmetic model
    for (int i = 0; i < 300; i++) begin
      case (i % 3)
        0: x = $urandom;
        1: x = {1'($urandom), 8'($urandom_range(160, 118)), 23'($urandom)};
        default: x = {1'($urandom), 8'($urandom_range(158, 124)), 23'($urandom_range(3, 0) << 20)};
      endcase
      model(x, er, einv, einx, elat);
      run_and_check($sformatf("rand %h", x), x, er, einv, einx, elat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
